// File: rtl/buzz_note_player.sv
// Switch-driven square-wave note player: key selection (lowest or last-pressed),
// octave shift, optional release tail, single driver of the buzzer pin.
module buzz_note_player #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int N_KEYS   = 7,
    parameter int MODE     = 0,
    parameter int TAIL_CYC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] switch,
    input  logic [1:0]        octave,
    input  logic              enable,
    output logic              speaker,
    output logic              active,
    output logic [3:0]        note_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;

    localparam logic [31:0] TAIL_LD = (TAIL_CYC > 0) ? 32'(TAIL_CYC - 1) : 32'd0;

    logic [N_KEYS-1:0] r_sw_m, r_sw_s, r_sw_p;
    logic [1:0]        r_oct;
    logic              r_en;
    logic [1:0]        r_state;
    logic [31:0]       r_cnt, r_tail;
    logic              r_spk;
    logic [3:0]        r_note;

    logic [N_KEYS-1:0] w_rise;
    logic              w_any, w_held, w_wrap;
    logic [3:0]        w_sel;
    logic [31:0]       w_hp, w_shift, w_hpe;

    // Half-period in clocks of C4..B4; every branch is a constant expression.
    function automatic logic [31:0] f_hp(input logic [3:0] i);
        case (i)
            4'd0:    f_hp = 32'(CLK_HZ / (2 * 262));
            4'd1:    f_hp = 32'(CLK_HZ / (2 * 277));
            4'd2:    f_hp = 32'(CLK_HZ / (2 * 294));
            4'd3:    f_hp = 32'(CLK_HZ / (2 * 311));
            4'd4:    f_hp = 32'(CLK_HZ / (2 * 330));
            4'd5:    f_hp = 32'(CLK_HZ / (2 * 349));
            4'd6:    f_hp = 32'(CLK_HZ / (2 * 370));
            4'd7:    f_hp = 32'(CLK_HZ / (2 * 392));
            4'd8:    f_hp = 32'(CLK_HZ / (2 * 415));
            4'd9:    f_hp = 32'(CLK_HZ / (2 * 440));
            4'd10:   f_hp = 32'(CLK_HZ / (2 * 466));
            default: f_hp = 32'(CLK_HZ / (2 * 494));
        endcase
    endfunction

    function automatic logic [3:0] f_lowest(input logic [N_KEYS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N_KEYS - 1; i >= 0; i--)
            if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    assign w_hp    = f_hp(r_note);
    assign w_shift = w_hp >> r_oct;
    assign w_hpe   = (w_shift == 32'd0) ? 32'd1 : w_shift;
    // >= so that an octave raise mid-note toggles at once instead of wrapping the counter
    assign w_wrap  = (r_cnt >= w_hpe - 32'd1);
    assign w_rise  = r_sw_s & ~r_sw_p;
    assign w_any   = |r_sw_s;

    always_comb begin
        w_held = 1'b0;
        for (int i = 0; i < N_KEYS; i++)
            if (r_note == 4'(i)) w_held = r_sw_s[i];
        w_sel = f_lowest(r_sw_s);
        if (MODE == 1) begin
            if (|w_rise)     w_sel = f_lowest(w_rise);
            else if (w_held) w_sel = r_note;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_m  <= '0;
            r_sw_s  <= '0;
            r_sw_p  <= '0;
            r_oct   <= 2'd0;
            r_en    <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= 32'd0;
            r_tail  <= 32'd0;
            r_spk   <= 1'b0;
            r_note  <= 4'd0;
        end else begin
            r_sw_m <= switch;
            r_sw_s <= r_sw_m;
            r_sw_p <= r_sw_s;
            r_oct  <= octave;
            r_en   <= enable;
            if (!r_en) begin
                r_state <= S_IDLE;
                r_cnt   <= 32'd0;
                r_tail  <= 32'd0;
                r_spk   <= 1'b0;
            end else begin
                // Tone step first; state branches below override it on load/stop.
                if (r_state != S_IDLE) begin
                    if (w_wrap) begin
                        r_spk <= ~r_spk;
                        r_cnt <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_any) begin
                            r_note  <= w_sel;
                            r_cnt   <= 32'd0;
                            r_spk   <= 1'b0;
                            r_state <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (!w_any) begin
                            if (TAIL_CYC == 0) begin
                                r_state <= S_IDLE;
                                r_cnt   <= 32'd0;
                                r_spk   <= 1'b0;
                            end else begin
                                r_state <= S_TAIL;
                                r_tail  <= TAIL_LD;
                            end
                        end else if (w_sel != r_note) begin
                            r_note <= w_sel;
                            r_cnt  <= 32'd0;
                            r_spk  <= 1'b0;
                        end
                    end
                    S_TAIL: begin
                        if (w_any) begin
                            r_note  <= w_sel;
                            r_cnt   <= 32'd0;
                            r_spk   <= 1'b0;
                            r_tail  <= 32'd0;
                            r_state <= S_PLAY;
                        end else if (r_tail == 32'd0) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 32'd0;
                            r_spk   <= 1'b0;
                        end else begin
                            r_tail <= r_tail - 32'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= 32'd0;
                        r_tail  <= 32'd0;
                        r_spk   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign speaker  = r_spk;
    assign active   = (r_state == S_PLAY) || (r_state == S_TAIL);
    assign note_idx = r_note;

endmodule

// File: tb/tb_buzz_note_player.sv
// Two players share one stimulus: u0 lowest-key/no tail, u1 last-pressed/5000-cycle tail.
module tb_buzz_note_player;

    localparam int CLK  = 1_000_000;
    localparam int TAIL = 5000;

    typedef struct {
        int note;
        int hp;     // -1: interval straddles an octave change, only the note is checked
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [11:0]     sw = 12'hFFF;
    logic [1:0]      oct = 2'd0;
    logic            en = 1'b1;
    logic [1:0]      spk, act;
    logic [1:0][3:0] nt;

    int   n_tests = 0, n_fail = 0;
    exp_t q0[$], q1[$];
    int   freq[12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

    logic [11:0] sw_cur;
    int          oct_cur, sel0, sel1;

    always #5 clk = ~clk;

    buzz_note_player #(.CLK_HZ(CLK), .N_KEYS(12), .MODE(0), .TAIL_CYC(0)) u0 (
        .clk(clk), .rst_n(rst_n), .switch(sw), .octave(oct), .enable(en),
        .speaker(spk[0]), .active(act[0]), .note_idx(nt[0]));

    buzz_note_player #(.CLK_HZ(CLK), .N_KEYS(12), .MODE(1), .TAIL_CYC(TAIL)) u1 (
        .clk(clk), .rst_n(rst_n), .switch(sw), .octave(oct), .enable(en),
        .speaker(spk[1]), .active(act[1]), .note_idx(nt[1]));

    function automatic void chk(string nm, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endfunction

    function automatic int hpm(int k, int o);
        int v;
        v = (CLK / (2 * freq[k])) >> o;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int lowest(logic [11:0] v);
        int r;
        r = 0;
        for (int i = 11; i >= 0; i--)
            if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: a restart is an activation or note change; a toggle while active closes a half-period.
    int          cyc = 0;
    logic [1:0]      p_act = '0, p_spk = '0;
    logic [1:0][3:0] p_nt = '0;
    int          last[2] = '{0, 0};

    always @(negedge clk) begin
        int   iv;
        exp_t e;
        bit   got;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (act[d] && (!p_act[d] || nt[d] != p_nt[d])) begin
                last[d] = cyc;
                chk($sformatf("u%0d_restart_speaker", d), int'(spk[d]), 0);
            end else if (act[d] && spk[d] != p_spk[d]) begin
                iv = cyc - last[d];
                last[d] = cyc;
                got = 1'b0;
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                if (got) begin
                    chk($sformatf("u%0d_note", d), int'(nt[d]), e.note);
                    if (e.hp >= 0) chk($sformatf("u%0d_half_period", d), iv, e.hp);
                end
            end
            p_act[d] = act[d];
            p_spk[d] = spk[d];
            p_nt[d]  = nt[d];
        end
    end

    task automatic push(int d, int note, int hp, int n, bit skip);
        exp_t e;
        e.note = note;
        if (skip) begin
            e.hp = -1;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        e.hp = hp;
        for (int i = 0; i < n; i++)
            if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 8000) begin
            @(negedge clk);
            t++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            chk("drain_timeout_pending", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
    endtask

    // Apply a nonzero key vector; model: u0 takes the lowest key, u1 the lowest new press,
    // else keeps a still-held selection, else falls back to the lowest held key.
    task automatic apply(logic [11:0] s, int o, int n);
        logic [11:0] p;
        bit          och;
        p   = s & ~sw_cur;
        och = (o != oct_cur);
        sel0 = lowest(s);
        if (p != 0)        sel1 = lowest(p);
        else if (!s[sel1]) sel1 = lowest(s);
        @(negedge clk);
        sw = s;
        oct = 2'(o);
        sw_cur = s;
        oct_cur = o;
        repeat (6) @(negedge clk);
        push(0, sel0, hpm(sel0, o), n, och);
        push(1, sel1, hpm(sel1, o), n, och);
        drain();
    endtask

    task automatic release_all();
        @(negedge clk);
        sw = 12'h000;
        sw_cur = 12'h000;
    endtask

    initial begin
        int first[2];
        int t, n;

        // Reset held with every key down and enable high
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("u%0d_rst_speaker", d), int'(spk[d]), 0);
                chk($sformatf("u%0d_rst_active", d), int'(act[d]), 0);
                chk($sformatf("u%0d_rst_note", d), int'(nt[d]), 0);
            end
        end
        rst_n = 1'b1;
        first = '{-1, -1};
        t = 0;
        while ((first[0] < 0 || first[1] < 0) && t < 3000) begin
            @(negedge clk);
            t++;
            for (int d = 0; d < 2; d++)
                if (first[d] < 0 && spk[d]) first[d] = t;
        end
        chk("u0_first_rise", first[0], 3 + hpm(0, 0));
        chk("u1_first_rise", first[1], 3 + hpm(0, 0));
        sw_cur = 12'hFFF; oct_cur = 0; sel0 = 0; sel1 = 0;

        apply(12'h200, 0, 2);    // key 9, 1136
        apply(12'h200, 2, 2);    // octave 2, 284
        apply(12'h014, 0, 2);    // keys 4+2 -> 2
        apply(12'h010, 0, 2);    // release 2 -> 4
        apply(12'h001, 1, 2);    // key 0
        apply(12'h081, 1, 2);    // add 7: u1 follows, u0 stays
        apply(12'h001, 1, 2);    // release 7 -> 0

        // Release tail
        apply(12'h200, 1, 1);
        release_all();
        push(1, 9, hpm(9, 1), 2, 1'b0);
        t = 0;
        while (act[0] && t < 20) begin @(negedge clk); t++; end
        chk("u0_stop_after_release", int'(act[0]), 0);
        n = 0;
        while (act[1] && n < TAIL + 500) begin @(negedge clk); n++; end
        chk("u1_tail_len", n, TAIL);
        chk("u1_tail_end_speaker", int'(spk[1]), 0);
        drain();

        // Key press during tail
        apply(12'h200, 1, 0);
        release_all();
        repeat (1000) @(negedge clk);
        chk("u1_in_tail", int'(act[1]), 1);
        chk("u0_idle", int'(act[0]), 0);
        apply(12'h001, 1, 2);
        chk("u1_tail_repress_note", int'(nt[1]), 0);
        chk("u1_tail_repress_active", int'(act[1]), 1);

        // Randomized key vectors and octaves
        for (int i = 0; i < 12; i++)
            apply(12'($urandom_range(1, 4095)), $urandom_range(1, 3), 2);

        // Mute, then resume
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d_mute_speaker", d), int'(spk[d]), 0);
            chk($sformatf("u%0d_mute_active", d), int'(act[d]), 0);
        end
        en = 1'b1;
        apply(sw_cur, oct_cur, 2);

        // Asynchronous reset between edges
        apply(12'h020, 2, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d_async_speaker", d), int'(spk[d]), 0);
            chk($sformatf("u%0d_async_active", d), int'(act[d]), 0);
            chk($sformatf("u%0d_async_note", d), int'(nt[d]), 0);
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
